prf_wb_arbiter: RTL and testbench

Writeback arbiter that sits between the execution units and the physical register file's single write port. It accepts result writes from NUM_SRC execution sources over valid/ready handshakes, buffers each source in a 2-entry skid FIFO, and selects one write per cycle round-robin. It drives the PRF write port (we / rd_phys / rd_val) from registered outputs. It also maintains the per-physical-register ready scoreboard consumed by issue logic.

---
 rtl/ooo_pkg.sv | 17 +
 rtl/wb_skid_fifo.sv | 52 +++++
 rtl/prf_wb_arbiter.sv | 118 +++++++++++
 tb/tb_prf_wb_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ooo_pkg.sv
// Shared types and helpers for the out-of-order writeback path.
// Holds the physical register file geometry, the writeback request type and the round-robin step.
package ooo_pkg;

  localparam int unsigned PHYS_REGS = 64;
  localparam int unsigned PHYS_W    = $clog2(PHYS_REGS);

  typedef struct packed {
    logic [PHYS_W-1:0] phys;
    logic [31:0]       val;
  } wb_req_t;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry FIFO of writeback requests, one per execution source.
// Supports push and pop on the same edge with order preserved.
module wb_skid_fifo
  import ooo_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  wb_req_t    push_data,
  input  logic       pop,
  output wb_req_t    head,
  output logic [1:0] count
);

  wb_req_t    mem_q [2];
  logic       rd_ptr_q, wr_ptr_q;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q != 2'd2) || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/prf_wb_arbiter.sv
// Round-robin writeback arbiter in front of the single PRF write port.
// Also owns the per-physical-register ready scoreboard seen by issue.
module prf_wb_arbiter
  import ooo_pkg::*;
#(
  parameter int unsigned NUM_SRC = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SRC-1:0]          src_valid,
  output logic [NUM_SRC-1:0]          src_ready,
  input  logic [NUM_SRC*PHYS_W-1:0]   src_phys,
  input  logic [NUM_SRC*32-1:0]       src_val,
  output logic                        wb_we,
  output logic [PHYS_W-1:0]           wb_phys,
  output logic [31:0]                 wb_val,
  input  logic                        alloc_valid,
  input  logic [PHYS_W-1:0]           alloc_phys,
  output logic [PHYS_REGS-1:0]        ready_vec
);

  localparam int unsigned PtrW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  wb_req_t             head [NUM_SRC];
  logic [1:0]          fifo_count [NUM_SRC];
  logic [NUM_SRC-1:0]  head_valid;
  logic [NUM_SRC-1:0]  gnt_vec;
  logic                gnt_any;
  logic [PtrW-1:0]     gnt_idx, idx;
  wb_req_t             gnt_req;

  logic [PtrW-1:0]      rr_q, rr_d;
  logic                 wb_we_q;
  logic [PHYS_W-1:0]    wb_phys_q;
  logic [31:0]          wb_val_q;
  logic [PHYS_REGS-1:0] ready_q, ready_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    wb_req_t in_req;
    logic    push;

    assign in_req.phys   = src_phys[i*PHYS_W +: PHYS_W];
    assign in_req.val    = src_val[i*32 +: 32];
    assign src_ready[i]  = (fifo_count[i] != 2'd2);
    assign head_valid[i] = (fifo_count[i] != 2'd0);
    // Writes to phys 0 complete the handshake but are dropped here.
    assign push = src_valid[i] && src_ready[i] && (in_req.phys != '0);

    wb_skid_fifo u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (in_req),
      .pop       (gnt_vec[i]),
      .head      (head[i]),
      .count     (fifo_count[i])
    );
  end

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    gnt_vec = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = PtrW'((32'(rr_q) + k) % NUM_SRC);
      if (!gnt_any && head_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
    if (gnt_any) gnt_vec[gnt_idx] = 1'b1;
  end

  always_comb begin
    gnt_req = head[0];
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (gnt_vec[i]) gnt_req = head[i];
    end
  end

  assign rr_d = gnt_any ? PtrW'(rr_next(32'(gnt_idx), NUM_SRC)) : rr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q      <= '0;
      wb_we_q   <= 1'b0;
      wb_phys_q <= '0;
      wb_val_q  <= '0;
    end else begin
      rr_q    <= rr_d;
      wb_we_q <= gnt_any;
      if (gnt_any) begin
        wb_phys_q <= gnt_req.phys;
        wb_val_q  <= gnt_req.val;
      end
    end
  end

  // Clear from rename wins over a same-edge writeback set.
  always_comb begin
    ready_d = ready_q;
    if (wb_we_q)     ready_d[wb_phys_q]  = 1'b1;
    if (alloc_valid) ready_d[alloc_phys] = 1'b0;
    ready_d[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ready_q <= '1;
    else     ready_q <= ready_d;
  end

  assign wb_we     = wb_we_q;
  assign wb_phys   = wb_phys_q;
  assign wb_val    = wb_val_q;
  assign ready_vec = ready_q;

endmodule

// File: tb/tb_prf_wb_arbiter.sv
// Directed self-checking bench for prf_wb_arbiter.
// Expected PRF writes are queued as stimulus is driven and popped whenever wb_we is seen.
module tb_prf_wb_arbiter;
  import ooo_pkg::*;

  localparam int unsigned NS = 3;

  logic                    clk, rst;
  logic [NS-1:0]           src_valid, src_ready;
  logic [NS*PHYS_W-1:0]    src_phys;
  logic [NS*32-1:0]        src_val;
  logic                    wb_we;
  logic [PHYS_W-1:0]       wb_phys;
  logic [31:0]             wb_val;
  logic                    alloc_valid;
  logic [PHYS_W-1:0]       alloc_phys;
  logic [PHYS_REGS-1:0]    ready_vec;

  int unsigned total, passed;
  logic [37:0] exp_q [$];
  logic [37:0] exp_w;

  prf_wb_arbiter #(.NUM_SRC(NS)) dut (
    .clk         (clk),
    .rst         (rst),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .src_phys    (src_phys),
    .src_val     (src_val),
    .wb_we       (wb_we),
    .wb_phys     (wb_phys),
    .wb_val      (wb_val),
    .alloc_valid (alloc_valid),
    .alloc_phys  (alloc_phys),
    .ready_vec   (ready_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive_src(input logic [1:0] i, input logic v, input logic [5:0] p,
                           input logic [31:0] d);
    src_valid[i]           = v;
    src_phys[i*6 +: 6]     = p;
    src_val[i*32 +: 32]    = d;
  endtask

  task automatic expect_wr(input logic [5:0] p, input logic [31:0] d);
    exp_q.push_back({p, d});
  endtask

  // Advance one edge, then check any PRF write against the scoreboard.
  task automatic tick();
    @(posedge clk);
    #1;
    if (wb_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(wb_we), 64'd0);
      end else begin
        exp_w = exp_q.pop_front();
        check("wb_write", 64'({wb_phys, wb_val}), 64'(exp_w));
      end
    end
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst = 1'b1;
    src_valid = '0;
    src_phys = '0;
    src_val = '0;
    alloc_valid = 1'b0;
    alloc_phys = '0;

    // Reset
    tick();
    tick();
    check("rst_wb_we", 64'(wb_we), 64'd0);
    check("rst_wb_phys", 64'(wb_phys), 64'd0);
    check("rst_wb_val", 64'(wb_val), 64'd0);
    check("rst_src_ready", 64'(src_ready), 64'h7);
    check("rst_ready_vec", ready_vec, 64'hFFFF_FFFF_FFFF_FFFF);

    // Contention from rr_ptr=0, then sources 1 and 2 keep pushing until their FIFOs fill
    rst = 1'b0;
    drive_src(0, 1'b1, 6'd10, 32'hA000_0010);
    drive_src(1, 1'b1, 6'd11, 32'hA000_0011);
    drive_src(2, 1'b1, 6'd12, 32'hA000_0012);
    expect_wr(6'd10, 32'hA000_0010);
    expect_wr(6'd11, 32'hA000_0011);
    expect_wr(6'd12, 32'hA000_0012);
    tick();
    check("cont_no_same_edge_we", 64'(wb_we), 64'd0);
    drive_src(0, 1'b0, 6'd0, 32'h0);
    drive_src(1, 1'b1, 6'd21, 32'hB000_0021);
    drive_src(2, 1'b1, 6'd22, 32'hB000_0022);
    expect_wr(6'd21, 32'hB000_0021);
    expect_wr(6'd22, 32'hB000_0022);
    tick();
    check("cont_full_ready", 64'(src_ready), 64'h1);
    // Presented while full: must be refused and never written
    drive_src(1, 1'b1, 6'd31, 32'hC000_0031);
    drive_src(2, 1'b1, 6'd32, 32'hC000_0032);
    tick();
    check("cont_ready_after_pop1", 64'(src_ready), 64'h3);
    drive_src(1, 1'b0, 6'd0, 32'h0);
    drive_src(2, 1'b0, 6'd0, 32'h0);
    repeat (5) tick();
    check("cont_drained", 64'(exp_q.size()), 64'd0);

    // Single write with ready bit latency
    alloc_valid = 1'b1;
    alloc_phys  = 6'd5;
    tick();
    check("alloc_clears_5", 64'(ready_vec[5]), 64'd0);
    alloc_valid = 1'b0;
    drive_src(1, 1'b1, 6'd5, 32'hDEAD_BEEF);
    expect_wr(6'd5, 32'hDEAD_BEEF);
    tick();
    check("single_e0_no_we", 64'(wb_we), 64'd0);
    drive_src(1, 1'b0, 6'd0, 32'h0);
    tick();
    check("single_e1_we", 64'(wb_we), 64'd1);
    check("single_e1_ready5", 64'(ready_vec[5]), 64'd0);
    tick();
    check("single_e2_ready5", 64'(ready_vec[5]), 64'd1);

    // Phys 0 accepted and discarded, twice so any enqueue would show in src_ready
    drive_src(0, 1'b1, 6'd0, 32'h0000_1234);
    tick();
    check("phys0_ready_a", 64'(src_ready), 64'h7);
    tick();
    check("phys0_ready_b", 64'(src_ready), 64'h7);
    drive_src(0, 1'b0, 6'd0, 32'h0);
    repeat (3) tick();
    check("phys0_ready_vec0", 64'(ready_vec[0]), 64'd1);

    // Collision: alloc of 7 on the edge that would set ready_vec[7]
    drive_src(0, 1'b1, 6'd7, 32'h7777_0007);
    expect_wr(6'd7, 32'h7777_0007);
    tick();
    drive_src(0, 1'b0, 6'd0, 32'h0);
    tick();
    check("coll_we", 64'({wb_we, wb_phys}), 64'({1'b1, 6'd7}));
    alloc_valid = 1'b1;
    alloc_phys  = 6'd7;
    tick();
    check("coll_clear_wins", 64'(ready_vec[7]), 64'd0);
    alloc_valid = 1'b0;
    tick();
    check("coll_stays_clear", 64'(ready_vec[7]), 64'd0);

    // Reset mid-operation; rr_ptr is 1 here so 42 is the only write before reset
    drive_src(0, 1'b1, 6'd41, 32'hD000_0041);
    drive_src(1, 1'b1, 6'd42, 32'hD000_0042);
    drive_src(2, 1'b1, 6'd43, 32'hD000_0043);
    expect_wr(6'd42, 32'hD000_0042);
    tick();
    drive_src(0, 1'b1, 6'd51, 32'hE000_0051);
    drive_src(1, 1'b1, 6'd52, 32'hE000_0052);
    drive_src(2, 1'b1, 6'd53, 32'hE000_0053);
    tick();
    check("mid_filled_ready", 64'(src_ready), 64'h2);
    src_valid = '0;
    rst = 1'b1;
    tick();
    check("mid_rst_we", 64'(wb_we), 64'd0);
    check("mid_rst_ready", 64'(src_ready), 64'h7);
    check("mid_rst_ready_vec", ready_vec, 64'hFFFF_FFFF_FFFF_FFFF);
    rst = 1'b0;
    repeat (6) tick();
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
